btn_irq_controller: RTL and testbench

Turns the Atlys push-buttons into debounced level signals and a prioritised, maskable interrupt request for `processor_16`. Sits between the board `btn` pins and the processor `IRQ` input, and replaces the constant-zero IRQ register in the board top level. Runs on the divided processor clock and exposes the pending bits and the winning button index to the processor.

---
 rtl/btn_irq_pkg.sv | 20 ++
 rtl/btn_debounce.sv | 58 +++++
 rtl/btn_irq_controller.sv | 101 ++++++++++
 tb/tb_btn_irq_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_irq_pkg.sv
// Shared constants and the lowest-set-bit priority helper for button interrupt sources.
package btn_irq_pkg;

  localparam int N_BTN_DEF = 6;
  localparam int ID_W      = $clog2(N_BTN_DEF);

  // Widest source vector the priority helper accepts; callers zero-extend into it.
  localparam int MAX_SRC  = 32;
  localparam int SRC_ID_W = $clog2(MAX_SRC);

  function automatic logic [SRC_ID_W-1:0] lowest_set(input logic [MAX_SRC-1:0] v);
    logic [SRC_ID_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = SRC_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, tick-sampled stability counter, debounced level and rise pulse.
module btn_debounce
  import btn_irq_pkg::*;
#(
  parameter int STABLE_COUNT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int              CNT_W    = $clog2(STABLE_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT);

  logic             r_sync_a;
  logic             r_sync_b;
  logic             r_level;
  logic             r_level_d;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync_a  <= 1'b0;
      r_sync_b  <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_rise    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync_a  <= btn;
      r_sync_b  <= r_sync_a;
      r_level_d <= r_level;
      r_rise    <= r_level & ~r_level_d;
      // Any agreeing sample discards the run, so only an unbroken mismatch flips the level.
      if (tick) begin
        if (r_sync_b == r_level) begin
          r_cnt <= '0;
        end else if (w_cnt_inc == CNT_LAST) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/btn_irq_controller.sv
// Debounced push-buttons feeding a sticky pending register and a registered,
// maskable, lowest-index-first interrupt request with acknowledge.
module btn_irq_controller
  import btn_irq_pkg::*;
#(
  parameter int N_BTN        = N_BTN_DEF,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_COUNT = 16,
  parameter int IRQ_ID_W     = (N_BTN == N_BTN_DEF) ? ID_W :
                               ((N_BTN > 1) ? $clog2(N_BTN) : 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_BTN-1:0]    btn,
  input  logic [N_BTN-1:0]    irq_mask,
  input  logic                irq_ack,
  output logic                irq,
  output logic [IRQ_ID_W-1:0] irq_id,
  output logic [N_BTN-1:0]    irq_pending,
  output logic [N_BTN-1:0]    btn_level
);

  localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0]   r_tick_cnt;
  logic                w_tick;
  logic [N_BTN-1:0]    w_level;
  logic [N_BTN-1:0]    w_rise;
  logic [N_BTN-1:0]    r_pending;
  logic [N_BTN-1:0]    w_eligible;
  logic [MAX_SRC-1:0]  w_elig_ext;
  logic [IRQ_ID_W-1:0] w_next_id;
  logic [N_BTN-1:0]    w_ack_clr;
  logic                r_irq;
  logic [IRQ_ID_W-1:0] r_irq_id;
  logic                r_ack_vld;
  logic [IRQ_ID_W-1:0] r_ack_id;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .STABLE_COUNT(STABLE_COUNT)
    ) u_debounce (
      .clock(clock),
      .reset(reset),
      .tick (w_tick),
      .btn  (btn[g]),
      .level(w_level[g]),
      .rise (w_rise[g])
    );
  end

  // Ack is captured together with the id it was issued against and applied one cycle later.
  always_comb begin
    w_ack_clr = '0;
    if (r_ack_vld) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (r_ack_id == IRQ_ID_W'(i)) w_ack_clr[i] = 1'b1;
      end
    end
  end

  assign w_eligible = r_pending & irq_mask;
  assign w_elig_ext = MAX_SRC'(w_eligible);
  assign w_next_id  = IRQ_ID_W'(lowest_set(w_elig_ext));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= '0;
      r_irq     <= 1'b0;
      r_irq_id  <= '0;
      r_ack_vld <= 1'b0;
      r_ack_id  <= '0;
    end else begin
      // A fresh edge outranks a coincident clear of the same bit.
      r_pending <= (r_pending & ~w_ack_clr) | w_rise;
      r_irq     <= |w_eligible;
      r_irq_id  <= w_next_id;
      r_ack_vld <= irq_ack & r_irq;
      r_ack_id  <= r_irq_id;
    end
  end

  assign irq         = r_irq;
  assign irq_id      = r_irq_id;
  assign irq_pending = r_pending;
  assign btn_level   = w_level;

endmodule

// File: tb/tb_btn_irq_controller.sv
// Directed bench: reset, press, bounce, priority/ack, mask table, ack/edge collision, reset mid-run.
module tb_btn_irq_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] btn = '0;
  logic [5:0] irq_mask = '0;
  logic       irq_ack = 1'b0;
  logic       irq;
  logic [2:0] irq_id;
  logic [5:0] irq_pending;
  logic [5:0] btn_level;

  int n_checks = 0;
  int n_errors = 0;

  btn_irq_controller #(
    .N_BTN(6), .TICK_DIV(4), .STABLE_COUNT(3)
  ) dut (
    .clock(clock), .reset(reset), .btn(btn), .irq_mask(irq_mask), .irq_ack(irq_ack),
    .irq(irq), .irq_id(irq_id), .irq_pending(irq_pending), .btn_level(btn_level)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0] mask;
    logic       exp_irq;
    logic [2:0] exp_id;
  } mvec_t;

  mvec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_lvl(input logic [5:0] exp, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clock);
      if (btn_level == exp) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL %s: btn_level=%0h expected %0h within %0d cycles", name, btn_level, exp, budget);
    end
  endtask

  task automatic wait_pend(input logic [5:0] exp, input int budget, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clock);
      if (irq_pending == exp) hit = 1'b1;
    end
    n_checks++;
    if (!hit) begin
      n_errors++;
      $display("FAIL %s: irq_pending=%0h expected %0h within %0d cycles", name, irq_pending, exp, budget);
    end
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1;
    @(negedge clock);
    irq_ack = 1'b0;
  endtask

  initial begin
    tbl[0] = '{mask: 6'h08, exp_irq: 1'b1, exp_id: 3'd3};
    tbl[1] = '{mask: 6'h00, exp_irq: 1'b0, exp_id: 3'd0};
    tbl[2] = '{mask: 6'h20, exp_irq: 1'b1, exp_id: 3'd5};
    tbl[3] = '{mask: 6'h28, exp_irq: 1'b1, exp_id: 3'd3};
    tbl[4] = '{mask: 6'h37, exp_irq: 1'b1, exp_id: 3'd5};
    tbl[5] = '{mask: 6'h17, exp_irq: 1'b0, exp_id: 3'd0};
    tbl[6] = '{mask: 6'h07, exp_irq: 1'b0, exp_id: 3'd0};
    tbl[7] = '{mask: 6'h3F, exp_irq: 1'b1, exp_id: 3'd3};

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_pend", 32'(irq_pending), 32'd0);
    chk("rst_level", 32'(btn_level), 32'd0);

    // Clean press of button 2
    irq_mask = 6'h3F;
    btn[2] = 1'b1;
    wait_lvl(6'h04, 15, "press_level");
    @(negedge clock);
    @(negedge clock);
    chk("press_irq_n2", 32'(irq), 32'd0);
    chk("press_pend", 32'(irq_pending), 32'h04);
    @(negedge clock);
    chk("press_irq_n3", 32'(irq), 32'd1);
    chk("press_id", 32'(irq_id), 32'd2);
    btn[2] = 1'b0;
    pulse_ack();
    @(negedge clock);
    chk("press_ack_pend", 32'(irq_pending), 32'd0);
    @(negedge clock);
    chk("press_ack_irq", 32'(irq), 32'd0);
    wait_lvl(6'h00, 40, "press_release");

    // Bounce on button 0: 5-cycle runs never reach 3 consecutive ticks
    for (int c = 0; c < 100; c++) begin
      if (c % 5 == 0) btn[0] = ~btn[0];
      @(negedge clock);
      chk("bounce", 32'({btn_level, irq_pending}), 32'd0);
    end
    btn[0] = 1'b0;

    // Priority and ack: buttons 4 and 1
    btn[4] = 1'b1;
    btn[1] = 1'b1;
    wait_pend(6'h12, 30, "prio_pend");
    @(negedge clock);
    chk("prio_irq", 32'(irq), 32'd1);
    chk("prio_id1", 32'(irq_id), 32'd1);
    pulse_ack();
    @(negedge clock);
    chk("prio_ack_pend", 32'(irq_pending), 32'h10);
    chk("prio_stale_id", 32'(irq_id), 32'd1);
    @(negedge clock);
    chk("prio_irq2", 32'(irq), 32'd1);
    chk("prio_id4", 32'(irq_id), 32'd4);
    pulse_ack();
    @(negedge clock);
    @(negedge clock);
    chk("prio_irq_drop", 32'(irq), 32'd0);
    chk("prio_pend0", 32'(irq_pending), 32'd0);
    btn[4] = 1'b0;
    btn[1] = 1'b0;
    wait_lvl(6'h00, 40, "prio_release");

    // Mask: buttons 3 and 5 pending with everything masked
    irq_mask = 6'h00;
    btn[3] = 1'b1;
    btn[5] = 1'b1;
    wait_pend(6'h28, 30, "mask_pend");
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("mask_irq_off", 32'(irq), 32'd0);
    end
    pulse_ack();
    @(negedge clock);
    @(negedge clock);
    chk("ack_noirq_pend", 32'(irq_pending), 32'h28);
    chk("ack_noirq_irq", 32'(irq), 32'd0);
    for (int v = 0; v < 8; v++) begin
      irq_mask = tbl[v].mask;
      @(negedge clock);
      chk($sformatf("mask_tbl%0d_irq", v), 32'(irq), 32'(tbl[v].exp_irq));
      chk($sformatf("mask_tbl%0d_id", v), 32'(irq_id), 32'(tbl[v].exp_id));
      chk($sformatf("mask_tbl%0d_pend", v), 32'(irq_pending), 32'h28);
    end
    pulse_ack();
    @(negedge clock);
    @(negedge clock);
    chk("mask_ack_id5", 32'(irq_id), 32'd5);
    chk("mask_ack_pend", 32'(irq_pending), 32'h20);

    // Ack of button 5 coincides with a fresh rise on button 5
    btn[3] = 1'b0;
    btn[5] = 1'b0;
    wait_lvl(6'h00, 40, "coll_release");
    btn[5] = 1'b1;
    wait_lvl(6'h20, 20, "coll_level");
    irq_ack = 1'b1;
    @(negedge clock);
    irq_ack = 1'b0;
    @(negedge clock);
    chk("coll_pend", 32'(irq_pending), 32'h20);
    @(negedge clock);
    chk("coll_pend2", 32'(irq_pending), 32'h20);
    chk("coll_irq", 32'(irq), 32'd1);
    chk("coll_id", 32'(irq_id), 32'd5);

    // Reset mid-operation: pending {1,5}, button 2 debouncing, buttons 2 and 5 held
    btn[1] = 1'b1;
    wait_pend(6'h22, 30, "rst_mid_pend");
    btn[1] = 1'b0;
    wait_lvl(6'h20, 40, "rst_mid_release");
    btn[2] = 1'b1;
    repeat (6) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_irq", 32'(irq), 32'd0);
    chk("mid_rst_id", 32'(irq_id), 32'd0);
    chk("mid_rst_pend", 32'(irq_pending), 32'd0);
    chk("mid_rst_level", 32'(btn_level), 32'd0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clock);
      if (k == 11) chk("mid_lvl_early", 32'(btn_level), 32'd0);
      if (k == 12) chk("mid_lvl_up", 32'(btn_level), 32'h24);
      if (k == 14) begin
        chk("mid_irq_early", 32'(irq), 32'd0);
        chk("mid_pend", 32'(irq_pending), 32'h24);
      end
      if (k == 15) begin
        chk("mid_irq", 32'(irq), 32'd1);
        chk("mid_id", 32'(irq_id), 32'd2);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
